// File: rtl/digital_lock_if.sv
// digital_lock_if: keypad input and lock status/display outputs of digital_lock.
interface digital_lock_if;
    logic [3:0]  key;
    logic        locked;
    logic        error;
    logic [47:0] displays;
    modport master (output key, input locked, error, displays);
    modport slave  (input key, output locked, error, displays);
endinterface

// File: rtl/digital_lock.sv
// digital_lock: 4-key passcode lock FSM with lock/error status and six 7-segment fields.
// Define DIGITALLOCK_LOCKOUT_EN to add a lockout after three consecutive failed unlocks.
module digital_lock #(
    parameter int CLOCK_FREQ      = 50000000,
    parameter int PASSCODE_LENGTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    digital_lock_if.slave bus
);
    localparam int          EW        = 4 * PASSCODE_LENGTH;
    localparam logic [31:0] TIMEOUT   = 32'(10 * CLOCK_FREQ);
    localparam logic [2:0]  LAST      = 3'(PASSCODE_LENGTH - 1);
    localparam logic [7:0]  SEG_U     = 8'hC1;
    localparam logic [7:0]  SEG_L     = 8'hC7;
    localparam logic [7:0]  SEG_E     = 8'h86;
    localparam logic [7:0]  SEG_DASH  = 8'hBF;
    localparam logic [7:0]  SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {UNLOCKED_ENTER, UNLOCKED_CONFIRM, LOCKED} state_t;

    state_t        state_q;
    logic [3:0]    key_q, key_prev_q;
    logic [EW-1:0] entry_q, cand_q, code_q, entry_d;
    logic [2:0]    count_q;
    logic [31:0]   tmr_q;
    logic          locked_q, error_q;
    logic [47:0]   disp_q;
    logic          press, done, pending, timeout, lockout;

`ifdef DIGITALLOCK_LOCKOUT_EN
    logic [1:0]  fails_q;
    logic [31:0] lock_tmr_q;
    assign lockout = lock_tmr_q != 32'd0;
`else
    assign lockout = 1'b0;
`endif

    // A multi-bit value keeps key_prev_q non-zero, so it never counts as a release.
    assign press   = $onehot(key_q) && key_prev_q == 4'd0 && !lockout;
    assign entry_d = EW'({entry_q, key_q});
    assign done    = press && count_q == LAST;
    assign pending = count_q != 3'd0 || state_q == UNLOCKED_CONFIRM;
    assign timeout = pending && tmr_q == TIMEOUT - 32'd1;

    function automatic logic [47:0] seg(state_t s, logic e, logic [2:0] n, logic lo);
        logic [47:0] f;
        f[47:40] = e ? SEG_E : (s == LOCKED ? SEG_L : SEG_U);
        for (int i = 0; i < 5; i++)
            f[8*i +: 8] = (i < int'(n) || (i == 4 && lo)) ? SEG_DASH : SEG_BLANK;
        return f;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= UNLOCKED_ENTER;
            key_q      <= 4'd0;
            key_prev_q <= 4'd0;
            entry_q    <= '0;
            cand_q     <= '0;
            code_q     <= '0;
            count_q    <= 3'd0;
            tmr_q      <= 32'd0;
            locked_q   <= 1'b0;
            error_q    <= 1'b0;
            disp_q     <= {SEG_U, {5{SEG_BLANK}}};
`ifdef DIGITALLOCK_LOCKOUT_EN
            fails_q    <= 2'd0;
            lock_tmr_q <= 32'd0;
`endif
        end else begin
            key_q      <= bus.key;
            key_prev_q <= key_q;
            disp_q     <= seg(state_q, error_q, count_q, lockout);
`ifdef DIGITALLOCK_LOCKOUT_EN
            if (lockout) lock_tmr_q <= lock_tmr_q - 32'd1;
`endif
            if (press) begin
                tmr_q   <= 32'd0;
                error_q <= 1'b0;
                if (done) begin
                    entry_q <= '0;
                    count_q <= 3'd0;
                    case (state_q)
                        UNLOCKED_ENTER: begin
                            cand_q  <= entry_d;
                            state_q <= UNLOCKED_CONFIRM;
                        end
                        UNLOCKED_CONFIRM: begin
                            if (entry_d == cand_q) begin
                                code_q   <= entry_d;
                                locked_q <= 1'b1;
                                state_q  <= LOCKED;
                            end else begin
                                error_q <= 1'b1;
                                state_q <= UNLOCKED_ENTER;
                            end
                            cand_q <= '0;
                        end
                        default: begin
                            if (entry_d == code_q) begin
                                locked_q <= 1'b0;
                                state_q  <= UNLOCKED_ENTER;
`ifdef DIGITALLOCK_LOCKOUT_EN
                                fails_q  <= 2'd0;
`endif
                            end else begin
                                error_q <= 1'b1;
`ifdef DIGITALLOCK_LOCKOUT_EN
                                if (fails_q == 2'd2) begin
                                    fails_q    <= 2'd0;
                                    lock_tmr_q <= TIMEOUT;
                                end else begin
                                    fails_q <= fails_q + 2'd1;
                                end
`endif
                            end
                        end
                    endcase
                end else begin
                    entry_q <= entry_d;
                    count_q <= count_q + 3'd1;
                end
            end else if (timeout) begin
                tmr_q   <= 32'd0;
                entry_q <= '0;
                count_q <= 3'd0;
                cand_q  <= '0;
                if (state_q == UNLOCKED_CONFIRM) state_q <= UNLOCKED_ENTER;
            end else begin
                tmr_q <= pending ? tmr_q + 32'd1 : 32'd0;
            end
        end
    end

    assign bus.locked   = locked_q;
    assign bus.error    = error_q;
    assign bus.displays = disp_q;
endmodule

// File: tb/tb_digital_lock.sv
// tb_digital_lock: table-driven key sequences plus timeout, held-key and reset corner cases.
module tb_digital_lock;
    localparam logic [47:0] U0 = 48'hC1FF_FFFF_FFFF;
    localparam logic [47:0] U1 = 48'hC1FF_FFFF_FFBF;
    localparam logic [47:0] U2 = 48'hC1FF_FFFF_BFBF;
    localparam logic [47:0] L0 = 48'hC7FF_FFFF_FFFF;
    localparam logic [47:0] L1 = 48'hC7FF_FFFF_FFBF;
    localparam logic [47:0] E0 = 48'h86FF_FFFF_FFFF;

    typedef struct {
        logic [11:0] ks;
        int          n;
        logic        lk;
        logic        er;
        logic [47:0] disp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    vec_t v [16];

    always #5 clk = ~clk;

    digital_lock_if bus ();

    digital_lock #(.CLOCK_FREQ(50), .PASSCODE_LENGTH(3)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    task automatic press(input logic [3:0] k);
        @(negedge clk) bus.key = k;
        @(negedge clk) bus.key = 4'd0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [47:0] got, input logic [47:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic status(input string nm, input logic lk, input logic er, input logic [47:0] d);
        chk({nm, " locked"}, {47'd0, bus.locked}, {47'd0, lk});
        chk({nm, " error"}, {47'd0, bus.error}, {47'd0, er});
        chk({nm, " displays"}, bus.displays, d);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        v[0]  = '{12'h841, 3, 1'b0, 1'b0, U0};
        v[1]  = '{12'h841, 3, 1'b1, 1'b0, L0};
        v[2]  = '{12'h241, 3, 1'b1, 1'b1, E0};
        v[3]  = '{12'h100, 1, 1'b1, 1'b0, L1};
        v[4]  = '{12'h110, 2, 1'b1, 1'b1, E0};
        v[5]  = '{12'h841, 3, 1'b0, 1'b0, U0};
        v[6]  = '{12'h221, 3, 1'b0, 1'b0, U0};
        v[7]  = '{12'h241, 3, 1'b0, 1'b1, E0};
        v[8]  = '{12'h200, 1, 1'b0, 1'b0, U1};
        v[9]  = '{12'h210, 2, 1'b0, 1'b0, U0};
        v[10] = '{12'h221, 3, 1'b1, 1'b0, L0};
        v[11] = '{12'h241, 3, 1'b1, 1'b1, E0};
        v[12] = '{12'h221, 3, 1'b0, 1'b0, U0};
        v[13] = '{12'h500, 1, 1'b0, 1'b0, U0};
        v[14] = '{12'h200, 1, 1'b0, 1'b0, U1};
        v[15] = '{12'h500, 1, 1'b0, 1'b0, U1};

        bus.key = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        status("reset", 1'b0, 1'b0, U0);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < v[i].n; j++) press(v[i].ks[11-4*j -: 4]);
            settle();
            status($sformatf("vec%0d", i), v[i].lk, v[i].er, v[i].disp);
        end

        do_reset();
        press(4'h1); press(4'h8); press(4'h2);
        repeat (501) @(negedge clk);
        press(4'h1); press(4'h8); press(4'h2);
        settle();
        status("timeout reentry", 1'b0, 1'b0, U0);
        press(4'h1); press(4'h8); press(4'h2);
        settle();
        status("timeout confirm", 1'b1, 1'b0, L0);

        do_reset();
        press(4'h1);
        repeat (480) @(negedge clk);
        press(4'h8); press(4'h2);
        settle();
        status("before timeout", 1'b0, 1'b0, U0);

        do_reset();
        @(negedge clk) bus.key = 4'h4;
        repeat (20) @(negedge clk);
        bus.key = 4'd0;
        settle();
        status("held key", 1'b0, 1'b0, U1);
        press(4'h8);
        settle();
        status("second press", 1'b0, 1'b0, U2);

        do_reset();
        press(4'h8); press(4'h4); press(4'h1);
        press(4'h8);
        settle();
        chk("mid confirm displays", bus.displays, U1);
        do_reset();
        status("reset mid confirm", 1'b0, 1'b0, U0);
        press(4'h8); press(4'h4); press(4'h1);
        settle();
        status("code discarded", 1'b0, 1'b0, U0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/digital_lock.md
Name: digital_lock

Overview:
- Keypad-driven digital lock state machine for a 4-key board, with lock/error status and six 7-segment display outputs.
- When unlocked, a passcode of PASSCODE_LENGTH one-hot key presses is entered and then confirmed to lock.
- When locked, entering the stored passcode unlocks.
- Top-level block; drives board LEDs and HEX displays directly.

Parameters:
- CLOCK_FREQ, 50000000, clock frequency in Hz; the inactivity timeout is 10*CLOCK_FREQ cycles.
- PASSCODE_LENGTH, 4, number of key presses per passcode (1..5).

Ports:
- clock  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- key  input  4  active-high key inputs; one-hot per press.
- locked  output  1  1 = locked.
- error  output  1  1 = last completed entry mismatched.
- displays  output  48  six 8-bit segment fields, active-low, {dp,g,f,e,d,c,b,a}; [47:40] leftmost.

Behaviour:
- Reset: locked=0, error=0, state UNLOCKED_ENTER, stored code cleared, entry buffer and digit count cleared, timeout counter cleared.
- Key press detection:
  - key is registered once.
  - A press is accepted when the registered value has exactly one bit set and the previous registered value was 0 (rising edge).
  - Multi-bit values are ignored and do not count as a release.
- Entry: each accepted press shifts its 4-bit one-hot code into the entry buffer, MSB-first, and increments the digit count. An entry completes at PASSCODE_LENGTH presses.
- States:
  - UNLOCKED_ENTER: on entry complete, store it as candidate code → UNLOCKED_CONFIRM. error unchanged.
  - UNLOCKED_CONFIRM, entry complete:
    - Match with candidate: commit as passcode, locked=1, error=0 → LOCKED.
    - Mismatch: error=1, discard candidate → UNLOCKED_ENTER.
  - LOCKED, entry complete:
    - Match with passcode: locked=0, error=0 → UNLOCKED_ENTER.
    - Mismatch: error=1, stay LOCKED.
- error clears on the next accepted key press; it otherwise persists indefinitely.
- Latency: locked/error update by the 2nd rising clock edge after the final key press is sampled.
- Timeout: counter resets on every accepted press and counts while a sequence is pending (digit count > 0, or state UNLOCKED_CONFIRM). When it reaches 10*CLOCK_FREQ cycles:
  - Clear the entry buffer and digit count.
  - Discard the candidate code.
  - UNLOCKED_CONFIRM → UNLOCKED_ENTER; LOCKED stays LOCKED.
  - error and locked are unchanged.
- Simultaneous timeout and accepted press: the press wins; the counter resets and the digit is taken.
- Reset mid-entry returns to the reset state and discards the stored passcode.
- Displays:
  - Field 5 state letter:
    - U = 8'hC1 (UNLOCKED_*).
    - L = 8'hC7 (LOCKED).
    - E = 8'h86 overrides whenever error=1.
  - Fields 0..4 show one dash (8'hBF) per entered digit, filling from field 0; all other fields are blank (8'hFF).
  - Displays are registered.

Optional Feature:
- DIGITALLOCK_LOCKOUT_EN defined:
  - A 3rd consecutive mismatch in LOCKED starts a 10*CLOCK_FREQ-cycle lockout.
  - During lockout all key presses are ignored and field 4 shows dash.
  - The mismatch counter clears on a successful unlock or on reset.
- DIGITALLOCK_LOCKOUT_EN undefined: unlimited attempts; there is no lockout logic.

Test Plan:
- Reset, then enter code 8-4-1 (key=8,4,1 presses, each 1 cycle high, 1 cycle low), then 8-4-1 again → locked=1, error=0, field5=C7.
- Unlocked: enter 8-4-1, then confirm with 8-4-2 → locked=0, error=1, field5=86. A further press clears error.
- Locked with 2-2-1: enter 2-2-1 → locked=0, error=0. Alternatively enter 2-4-1 → locked=1, error=1.
- Timeout (CLOCK_FREQ=50): reset, enter 1-8-2, idle 501 cycles, enter 1-8-2 → locked=0, error=0, state UNLOCKED_CONFIRM.
- Key=4'b0101 pressed, or key held high for many cycles → treated as at most one digit; the dash count increments by ≤1.
- Reset asserted mid-confirm → locked=0, error=0, displays = C1,FF,FF,FF,FF,FF on the next cycle.
